// File: rtl/commonlib_muxn_pkg.sv
// commonlib_muxn_pkg: shared constants and helpers for the commonlib mux family.
package commonlib_muxn_pkg;

  // Supported channel-count range for the round-robin mux.
  localparam int MAX_N = 16;
  localparam int MIN_N = 2;

  // Ceiling log2, evaluated at elaboration time for index widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/commonlib_rr_arbiter.sv
// commonlib_rr_arbiter: combinational round-robin arbiter.
// The request vector is rotated so that bit ptr lands at position 0, the
// lowest set bit is priority-encoded, and the offset is added back to ptr.
module commonlib_rr_arbiter
  import commonlib_muxn_pkg::*;
#(
  parameter  int N     = 8,
  localparam int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

  logic [2*N-1:0]   rot_full;
  logic [N-1:0]     req_rot;
  logic [SEL_W-1:0] offset;
  logic [SEL_W:0]   sum;
  logic [SEL_W:0]   wrapped;

  // Double-width shift: the low N bits are req rotated right by ptr.
  assign rot_full = {req, req} >> ptr;
  assign req_rot  = rot_full[N-1:0];

  // The low half already holds every request, so OR-ing the whole shifted
  // word is the same as OR-ing req.
  assign grant_valid = |rot_full;

  // Priority encode: lowest set bit of the rotated vector wins.
  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = SEL_W'(i);
    end
  end

  // Map the rotated offset back to an absolute channel index, modulo N.
  always_comb begin
    sum       = {1'b0, ptr} + {1'b0, offset};
    wrapped   = sum - N_EXT;
    grant_idx = (sum >= N_EXT) ? wrapped[SEL_W-1:0] : sum[SEL_W-1:0];
  end

endmodule

// File: rtl/commonlib_rr_muxn.sv
// commonlib_rr_muxn: N-channel round-robin streaming mux with a registered
// output stage. Optional packet locking is enabled by defining
// COMMONLIB_RR_MUXN_PKT_LOCK_EN (adds in_last / out_last).
//
// Handshake: a beat moves on any interface in a cycle where valid and ready
// are both 1 at the rising edge. Producers hold valid/data until accepted;
// in_ready never depends on in_data, only on in_valid, ptr, lock and the
// state of the output register.
module commonlib_rr_muxn
  import commonlib_muxn_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int WIDTH = 8,
  localparam int SEL_W = clog2(N)
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
  ,
  input  logic [N-1:0]       in_last,
  output logic               out_last
`endif
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_next;
  logic             load;
  logic             take;
  logic [N-1:0]     req;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;

  // Output register may accept a new beat when empty or being drained.
  assign load = !out_valid | out_ready;

`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
  logic lock_q;

  // While a packet is open only its channel may request; out_sel still holds
  // that channel because nothing else can transfer during the lock.
  assign req = lock_q ? (in_valid & (N'(1) << out_sel)) : in_valid;
`else
  assign req = in_valid;
`endif

  commonlib_rr_arbiter #(
    .N (N)
  ) u_arbiter (
    .req         (req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign take     = load & grant_valid;
  assign in_ready = (take && ASYNCRESETN) ? (N'(1) << grant_idx) : '0;
  assign ptr_next = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);

  // Select the granted channel's data slice.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register, priority pointer and packet lock.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_q     <= '0;
`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
      lock_q    <= 1'b0;
      out_last  <= 1'b0;
`endif
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
        out_last  <= in_last[grant_idx];
        if (in_last[grant_idx]) begin
          ptr_q  <= ptr_next;
          lock_q <= 1'b0;
        end else begin
          lock_q <= 1'b1;
        end
`else
        ptr_q     <= ptr_next;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_commonlib_rr_muxn.sv
// tb_commonlib_rr_muxn: directed bench for commonlib_rr_muxn (N=8, WIDTH=8).
// Packet-lock steps run when COMMONLIB_RR_MUXN_PKT_LOCK_EN is defined.
module tb_commonlib_rr_muxn;

  localparam int N     = 8;
  localparam int WIDTH = 8;

  logic             CLK;
  logic             ASYNCRESETN;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_sel;
`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
  logic [N-1:0]     in_last;
  logic             out_last;
`endif

  int tests  = 0;
  int failed = 0;

  commonlib_rr_muxn #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sel     (out_sel)
`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
    ,
    .in_last     (in_last),
    .out_last    (out_last)
`endif
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One cycle: advance past the rising edge, sample 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] sel, input logic [7:0] data);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sel"},   {29'd0, out_sel},   {29'd0, sel});
    chk({tag, "_data"},  {24'd0, out_data},  {24'd0, data});
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
  endtask

  initial begin
    // Reset with every channel requesting
    ASYNCRESETN = 1'b0;
    out_ready   = 1'b1;
    in_valid    = '1;
    set_default_data();
`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
    in_last     = '1;
`endif
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    chk("rst_sel",   {29'd0, out_sel},   32'd0);
    chk("rst_ready", {24'd0, in_ready},  32'd0);
    tick();
    tick();
    chk("rst_ready_clk", {24'd0, in_ready}, 32'd0);
    chk("rst_valid_clk", {31'd0, out_valid}, 32'd0);

    // Load A5 from channel 0, then hold it with out_ready low
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    in_valid    = 8'h01;
    in_data[7:0] = 8'hA5;
    out_ready   = 1'b0;
    #1;
    chk("pre_a5_ready", {24'd0, in_ready}, 32'h01);
    tick();
    chk_beat("a5", 3'd0, 8'hA5);

    // Asynchronous reset between edges with a beat held
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data",  {24'd0, out_data},  32'd0);
    chk("arst_sel",   {29'd0, out_sel},   32'd0);
    chk("arst_ready", {24'd0, in_ready},  32'd0);
    #2;
    ASYNCRESETN = 1'b1;
    in_valid    = '1;
    set_default_data();
    out_ready   = 1'b1;
    #1;
    chk("post_rst_ready", {24'd0, in_ready}, 32'h01);

    // Full contention: 0..7 then 0, one beat per cycle
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_beat($sformatf("full%0d", k), 3'(k % 8), 8'h10 + 8'(k % 8));
      chk($sformatf("full%0d_ready", k), {24'd0, in_ready}, 32'd1 << ((k + 1) % 8));
    end

    // Backpressure: register holds channel 0 beat, no input accepted
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", {24'd0, in_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_beat($sformatf("bp%0d", k), 3'd0, 8'h10);
      chk($sformatf("bp%0d_ready", k), {24'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {24'd0, in_ready}, 32'h02);
    tick();
    out_ready = 1'b0;
    chk_beat("bp_one", 3'd1, 8'h11);
    tick();
    chk_beat("bp_hold", 3'd1, 8'h11);
    out_ready = 1'b1;

    // Sparse: set ptr to 7 via channel 6, then channels 2 and 6
    in_valid = 8'h40;
    tick();
    chk_beat("sp_seed", 3'd6, 8'h16);
    in_valid = 8'h44;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_beat($sformatf("sp%0d", k), (k % 2 == 0) ? 3'd2 : 3'd6,
               (k % 2 == 0) ? 8'h12 : 8'h16);
    end
    // ptr must be 7: channel 7 wins over 6
    in_valid = 8'hC0;
    tick();
    chk_beat("sp_ptr7", 3'd7, 8'h17);

    // Idle drain: one beat from channel 3, then nothing
    in_valid = 8'h08;
    tick();
    chk_beat("dr_beat", 3'd3, 8'h13);
    in_valid = 8'h00;
    tick();
    chk("dr_idle0", {31'd0, out_valid}, 32'd0);
    tick();
    chk("dr_idle1", {31'd0, out_valid}, 32'd0);
    // ptr must be 4: channel 4 wins over 3
    in_valid = 8'h18;
    #1;
    chk("dr_ptr4_ready", {24'd0, in_ready}, 32'h10);
    tick();
    chk_beat("dr_ptr4", 3'd4, 8'h14);

`ifdef COMMONLIB_RR_MUXN_PKT_LOCK_EN
    // Packet lock: ptr to 1, then a 3-beat packet on channel 1 vs channel 0
    in_valid = 8'h01;
    tick();
    chk_beat("pk_seed", 3'd0, 8'h10);
    in_valid = 8'h03;
    in_last  = 8'hFD;
    #1;
    chk("pk_ready_b1", {24'd0, in_ready}, 32'h02);
    tick();
    chk_beat("pk_b1", 3'd1, 8'h11);
    chk("pk_b1_last", {31'd0, out_last}, 32'd0);
    chk("pk_ready_b2", {24'd0, in_ready}, 32'h02);
    tick();
    chk_beat("pk_b2", 3'd1, 8'h11);
    in_last = '1;
    #1;
    chk("pk_ready_b3", {24'd0, in_ready}, 32'h02);
    tick();
    chk_beat("pk_b3", 3'd1, 8'h11);
    chk("pk_b3_last", {31'd0, out_last}, 32'd1);
    chk("pk_ready_after", {24'd0, in_ready}, 32'h01);
    tick();
    chk_beat("pk_ch0", 3'd0, 8'h10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
